cost_argmin_scan: RTL and testbench

- Consumer of the packed per-block cost vector produced by the formula calculation stage.
- Input is NUM_BLK signed costs of COST_W bits each.
- Captures the vector on a start pulse, then scans it one entry per clock.
- Reports the minimum cost, its index (best disparity candidate), the second-lowest cost and an ambiguity flag. Results go to the downstream distance stage over a valid/ready handshake.

---
 rtl/cost_argmin_scan_pkg.sv | 19 +
 rtl/cost_argmin_scan_if.sv | 31 +++
 rtl/cost_min2_update.sv | 34 +++
 rtl/cost_argmin_scan.sv | 129 ++++++++++++
 tb/tb_cost_argmin_scan.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cost_argmin_scan_pkg.sv
// Shared types and defaults for the cost argmin scanner: the cost type,
// its most-positive value and the scan FSM states.
package cost_argmin_scan_pkg;

  localparam int DEF_NUM_BLK  = 64;
  localparam int DEF_COST_W   = 18;
  localparam int DEF_AMBIG_TH = 16;

  typedef logic signed [DEF_COST_W-1:0] cost_t;

  localparam cost_t COST_MAX = {1'b0, {(DEF_COST_W-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } state_t;

endpackage

// File: rtl/cost_argmin_scan_if.sv
// Request and result handshake bundle between the cost producer, the argmin
// scanner and the downstream distance stage.
interface cost_argmin_scan_if
  import cost_argmin_scan_pkg::*;
#(
  parameter int NUM_BLK = DEF_NUM_BLK,
  parameter int COST_W  = DEF_COST_W,
  parameter int IDX_W   = $clog2(DEF_NUM_BLK)
);

  logic                      start;
  logic [NUM_BLK*COST_W-1:0] cost_vec;
  logic                      busy;
  logic                      out_valid;
  logic                      out_ready;
  logic [IDX_W-1:0]          best_idx;
  logic signed [COST_W-1:0]  best_cost;
  logic signed [COST_W-1:0]  second_cost;
  logic                      ambiguous;

  modport master (
    output start, cost_vec, out_ready,
    input  busy, out_valid, best_idx, best_cost, second_cost, ambiguous
  );

  modport slave (
    input  start, cost_vec, out_ready,
    output busy, out_valid, best_idx, best_cost, second_cost, ambiguous
  );

endinterface

// File: rtl/cost_min2_update.sv
// Folds one cost entry into a running (min, second, idx) triple. Strict
// compares keep the lowest index on ties; an equal later entry lands in second.
module cost_min2_update
  import cost_argmin_scan_pkg::*;
#(
  parameter int COST_W = DEF_COST_W,
  parameter int IDX_W  = $clog2(DEF_NUM_BLK)
) (
  input  logic signed [COST_W-1:0] entry,
  input  logic [IDX_W-1:0]         entry_idx,
  input  logic signed [COST_W-1:0] cur_min,
  input  logic signed [COST_W-1:0] cur_second,
  input  logic [IDX_W-1:0]         cur_idx,
  output logic signed [COST_W-1:0] nxt_min,
  output logic signed [COST_W-1:0] nxt_second,
  output logic [IDX_W-1:0]         nxt_idx
);

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path through the block can infer a latch.
    nxt_min    = cur_min;
    nxt_second = cur_second;
    nxt_idx    = cur_idx;
    if (entry < cur_min) begin
      nxt_second = cur_min;
      nxt_min    = entry;
      nxt_idx    = entry_idx;
    end else if (entry < cur_second) begin
      nxt_second = entry;
    end
  end

endmodule

// File: rtl/cost_argmin_scan.sv
// Captures a packed cost vector on start, scans it one entry per clock and
// presents min / argmin / second-min / ambiguity over a valid/ready handshake.
module cost_argmin_scan
  import cost_argmin_scan_pkg::*;
#(
  parameter int NUM_BLK  = DEF_NUM_BLK,
  parameter int COST_W   = DEF_COST_W,
  parameter int IDX_W    = $clog2(DEF_NUM_BLK),
  parameter int AMBIG_TH = DEF_AMBIG_TH
) (
  input logic               sig,
  input logic               rst,
  cost_argmin_scan_if.slave bus
);

  localparam logic signed [COST_W-1:0] RUN_INIT = {1'b0, {(COST_W-1){1'b1}}};
  localparam logic signed [COST_W:0]   MARGIN_TH = (COST_W+1)'(AMBIG_TH);
  localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(NUM_BLK-1);

  state_t                   state;
  logic [IDX_W-1:0]         ptr;
  logic signed [COST_W-1:0] shadow [NUM_BLK];
  logic signed [COST_W-1:0] run_min;
  logic signed [COST_W-1:0] run_second;
  logic [IDX_W-1:0]         run_idx;

  logic signed [COST_W-1:0] nxt_min;
  logic signed [COST_W-1:0] nxt_second;
  logic [IDX_W-1:0]         nxt_idx;
  logic signed [COST_W:0]   margin;

  logic                     busy;
  logic                     out_valid;
  logic [IDX_W-1:0]         best_idx;
  logic signed [COST_W-1:0] best_cost;
  logic signed [COST_W-1:0] second_cost;
  logic                     ambiguous;

  cost_min2_update #(
    .COST_W (COST_W),
    .IDX_W  (IDX_W)
  ) u_update (
    .entry      (shadow[ptr]),
    .entry_idx  (ptr),
    .cur_min    (run_min),
    .cur_second (run_second),
    .cur_idx    (run_idx),
    .nxt_min    (nxt_min),
    .nxt_second (nxt_second),
    .nxt_idx    (nxt_idx)
  );

  // One extra bit keeps the difference of two extreme costs from wrapping.
  assign margin = {run_second[COST_W-1], run_second} - {run_min[COST_W-1], run_min};

  // NOTE: the shadow copy is a plain storage array with no reset; it is
  // always written on start before anything reads it.
  always_ff @(posedge sig) begin
    if (!rst && state == IDLE && bus.start) begin
      for (int k = 0; k < NUM_BLK; k++) begin
        shadow[k] <= bus.cost_vec[k*COST_W +: COST_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the pre-edge values of the others.
  always_ff @(posedge sig) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      run_min     <= '0;
      run_second  <= '0;
      run_idx     <= '0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      best_idx    <= '0;
      best_cost   <= '0;
      second_cost <= '0;
      ambiguous   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= SCAN;
            busy       <= 1'b1;
            ptr        <= '0;
            run_min    <= RUN_INIT;
            run_second <= RUN_INIT;
            run_idx    <= '0;
          end
        end
        SCAN: begin
          run_min    <= nxt_min;
          run_second <= nxt_second;
          run_idx    <= nxt_idx;
          if (ptr == LAST_IDX) begin
            state <= HOLD;
          end else begin
            ptr <= ptr + IDX_W'(1);
          end
        end
        HOLD: begin
          // First HOLD cycle publishes the settled running values.
          if (!out_valid) begin
            best_idx    <= run_idx;
            best_cost   <= run_min;
            second_cost <= run_second;
            ambiguous   <= (margin < MARGIN_TH);
            out_valid   <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy;
  assign bus.out_valid   = out_valid;
  assign bus.best_idx    = best_idx;
  assign bus.best_cost   = best_cost;
  assign bus.second_cost = second_cost;
  assign bus.ambiguous   = ambiguous;

endmodule

// File: tb/tb_cost_argmin_scan.sv
// Randomised and directed bench for cost_argmin_scan: a reference model fills a
// scoreboard queue at start time, a monitor pops and compares on each handshake.
module tb_cost_argmin_scan;
  import cost_argmin_scan_pkg::*;

  localparam int NB = DEF_NUM_BLK;
  localparam int CW = DEF_COST_W;
  localparam int IW = $clog2(DEF_NUM_BLK);
  localparam int TH = DEF_AMBIG_TH;

  typedef cost_t vec_t [NB];
  typedef struct {
    int idx;
    int best;
    int second;
    bit amb;
  } exp_t;

  logic sig = 1'b0;
  logic rst;

  always #5 sig = ~sig;

  cost_argmin_scan_if #(.NUM_BLK(NB), .COST_W(CW), .IDX_W(IW)) bus ();

  cost_argmin_scan #(
    .NUM_BLK  (NB),
    .COST_W   (CW),
    .IDX_W    (IW),
    .AMBIG_TH (TH)
  ) dut (
    .sig (sig),
    .rst (rst),
    .bus (bus)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: argmin is the first index holding the minimum value; second is
  // the minimum over every other index; margin in plain integer arithmetic.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    e.idx = 0;
    for (int k = 1; k < NB; k++)
      if (int'(v[k]) < int'(v[e.idx])) e.idx = k;
    e.best   = int'(v[e.idx]);
    e.second = 32'h7fff_ffff;
    for (int k = 0; k < NB; k++)
      if (k != e.idx && int'(v[k]) < e.second) e.second = int'(v[k]);
    e.amb = (e.second - e.best) < TH;
    return e;
  endfunction

  task automatic tick();
    @(posedge sig);
    #1;
  endtask

  task automatic drive_vec(input vec_t v);
    logic [NB*CW-1:0] p;
    for (int k = 0; k < NB; k++) p[k*CW +: CW] = v[k];
    bus.cost_vec = p;
  endtask

  function automatic vec_t rand_vec(input int lo, input int hi);
    vec_t v;
    for (int k = 0; k < NB; k++) v[k] = cost_t'(lo + int'($urandom_range(0, hi - lo)));
    return v;
  endfunction

  task automatic issue(input vec_t v, input bit push);
    drive_vec(v);
    bus.start = 1'b1;
    if (push) sb.push_back(model(v));
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic wait_accept(input bit random_ready);
    int n = 0;
    while (bus.out_valid && n < 300) begin
      bus.out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    bus.out_ready = 1'b1;
    check("handshake_done", bus.out_valid, 0);
    check("busy_after_accept", bus.busy, 0);
  endtask

  task automatic run(input vec_t v, input string tag, input bit random_ready);
    int cyc;
    issue(v, 1'b1);
    check({tag, "_busy_rise"}, bus.busy, 1);
    wait_valid(cyc);
    check({tag, "_latency"}, cyc, NB + 1);
    wait_accept(random_ready);
  endtask

  // Monitor: one scoreboard entry per accepted result.
  initial begin
    exp_t e;
    forever begin
      @(negedge sig);
      if (!rst && bus.out_valid && bus.out_ready) begin
        check("result_expected", longint'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("best_idx", bus.best_idx, e.idx);
          check("best_cost", bus.best_cost, e.best);
          check("second_cost", bus.second_cost, e.second);
          check("ambiguous", bus.ambiguous, e.amb);
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    exp_t e;
    int   cyc;
    int   seen;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    bus.cost_vec  = '0;
    repeat (3) tick();
    check("rst_busy", bus.busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_best_idx", bus.best_idx, 0);
    check("rst_best_cost", bus.best_cost, 0);
    check("rst_second_cost", bus.second_cost, 0);
    check("rst_ambiguous", bus.ambiguous, 0);
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    tick();

    for (int k = 0; k < NB; k++) v[k] = cost_t'(1000 - k);
    run(v, "descending", 1'b0);

    for (int k = 0; k < NB; k++) v[k] = cost_t'(500);
    v[20] = cost_t'(-300);
    run(v, "single_low", 1'b0);

    for (int k = 0; k < NB; k++) v[k] = cost_t'(2000);
    v[7]  = cost_t'(100);
    v[40] = cost_t'(100);
    run(v, "tie", 1'b0);

    for (int k = 0; k < NB; k++) v[k] = COST_MAX;
    v[0] = cost_t'(131071);
    v[1] = cost_t'(-131072);
    run(v, "extremes", 1'b0);

    for (int k = 0; k < NB; k++) v[k] = cost_t'(-77);
    run(v, "all_equal", 1'b0);

    // Backpressure with disturbing start / cost_vec activity mid-scan and in HOLD.
    bus.out_ready = 1'b0;
    v = rand_vec(-5000, 5000);
    issue(v, 1'b1);
    e = sb[sb.size()-1];
    repeat (20) tick();
    drive_vec(rand_vec(-9000, -8000));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_valid(cyc);
    check("bp_latency", cyc + 21, NB + 1);
    for (int i = 0; i < 10; i++) begin
      drive_vec(rand_vec(-9000, -8000));
      bus.start = 1'(i % 2);
      tick();
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_idx", bus.best_idx, e.idx);
      check("bp_hold_cost", bus.best_cost, e.best);
    end
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.start = 1'b0;
    check("bp_accepted", bus.out_valid, 0);
    seen = 0;
    repeat (80) begin
      tick();
      if (bus.out_valid || bus.busy) seen++;
    end
    check("bp_no_second_result", seen, 0);
    check("bp_fields_kept", bus.best_cost, e.best);

    // Reset in the middle of a scan aborts it without a result.
    issue(rand_vec(-100, 100), 1'b0);
    repeat (29) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_best_idx", bus.best_idx, 0);
    check("abort_best_cost", bus.best_cost, 0);
    check("abort_second_cost", bus.second_cost, 0);
    check("abort_ambiguous", bus.ambiguous, 0);
    run(rand_vec(-3000, 3000), "after_abort", 1'b0);

    // Random vectors: narrow ranges force ties and ambiguity, wide ones do not.
    for (int t = 0; t < 10; t++) begin
      if (t % 3 == 0) v = rand_vec(-131072, 131071);
      else            v = rand_vec(-20, 20);
      run(v, "random", 1'b1);
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
